cia_pipelined_adder: RTL and testbench
======================================

CIA_PIPELINED_ADDER -- requirements
Module: cia_pipelined_adder

Interface
REQ-001 The block SHALL have parameter N, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter BLK, default 4: carry-increment block width in bits.
REQ-003 The block SHALL be instantiated only with N % BLK == 0 and N >= BLK >= 1; other values are illegal. Define NB = N/BLK, the number of blocks and the pipeline latency.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-008 The block SHALL have port a, input, N bits: operand A.
REQ-009 The block SHALL have port b, input, N bits: operand B.
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-011 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port sum, output, N bits: result.
REQ-015 The block SHALL have port cout, output, 1 bit: carry-out. In subtract mode, 1 means no borrow.
REQ-016 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-017 Transfer rules:
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
REQ-018 Arithmetic per accepted operand set:
- Add mode: {cout,sum} = a + b + cin.
- Subtract mode: {cout,sum} = a + ~b + 1, with cin ignored.
- All arithmetic is N+1 bits wide, unsigned, and wraps modulo 2^(N+1).
REQ-019 ovf SHALL equal the carry into bit N-1 XOR the carry out of bit N-1.
REQ-020 Each BLK-bit block SHALL compute its local sum with carry-in 0 and the incremented sum. The carry from the lower block selects between them (carry-increment structure), and the block carry-out is generated accordingly.
REQ-021 Pipeline registers:
- A register boundary follows every block, giving exactly NB stages.
- Stage k resolves block k (block 0 = LSBs).
- Unresolved upper operand bits, resolved lower sum bits, the running carry, the carry into the MSB and a stage-valid bit travel with the data.
REQ-022 Latency: with no stall, a set accepted at edge t SHALL present out_valid=1 with its result after edge t+NB-1 (visible in cycle t+NB). Results emerge in acceptance order.
REQ-023 Throughput: the block SHALL sustain one accepted operand set per cycle while out_ready=1.
REQ-024 Advance and stall:
- Advance enable: adv = !out_valid || out_ready, a global stall.
- in_ready = adv while rst_n=1; in_ready = 0 while rst_n=0.
- When adv=0, all stage registers, including sum, cout, ovf and out_valid, SHALL hold.
REQ-025 Bubbles: a cycle with adv=1 and in_valid=0 SHALL insert a bubble (stage-valid 0) that propagates. Bubbles are never presented as out_valid=1.
REQ-026 Simultaneous events: an output transfer and an input transfer in the same cycle SHALL both complete with no loss or duplication.
REQ-027 Output stability: while out_valid=1 && out_ready=0, sum, cout and ovf SHALL remain stable.
REQ-028 Illegal inputs: the block SHALL ignore a, b, cin and sub when no input transfer occurs. in_valid asserted while in_ready=0 SHALL not be captured.

Reset
REQ-029 On a clock edge with rst_n=0:
- All stage-valid bits clear.
- out_valid = 0, sum = 0, cout = 0, ovf = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results, including one held under stall. No result of a pre-reset input SHALL ever appear afterward.
REQ-031 The first cycle with rst_n=1 after reset SHALL have in_ready=1, and an input transfer is allowed in that cycle.

Verification (N=16, BLK=4, NB=4, out_ready=1 unless stated)
REQ-032 a=16'hADC0, b=16'hFE80, cin=1, sub=0 -> 4 cycles later: sum=16'hAC41, cout=1, ovf=0.
REQ-033 Back-to-back cases:
- Case 1: a=16'h7FFF, b=16'h0001, cin=0, sub=0 -> sum=16'h8000, cout=0, ovf=1.
- Case 2 (next cycle): a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Both results SHALL appear on consecutive cycles.
REQ-034 Full carry propagation: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0.
REQ-035 Stall:
- Stimulus: 3 consecutive inputs (16'h3A9A+16'hE544 cin=0, then two more); out_ready=0 for 3 cycles once the first out_valid appears.
- Required: first result sum=16'h1FDE, cout=1 held stable; in_ready=0 throughout the stall; all 3 results delivered in order once out_ready=1.
REQ-036 Reset mid-flight: rst_n=0 for one edge with 2 sets in flight -> out_valid=0, sum=0 on the next cycle; no stale result appears in the following 8 cycles with in_valid=0.

Source files
------------

// File: rtl/cia_pipelined_adder.sv
// Pipelined carry-increment adder/subtractor: one BLK-bit block is resolved per stage,
// NB = N/BLK stages, one result per cycle when the consumer keeps up.
module cia_pipelined_adder #(
  parameter int N   = 16,
  parameter int BLK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NB = N / BLK;

  // Handshake: a transfer happens on any rising edge where valid && ready are both high.
  // The whole pipe advances together; a held output stalls every stage.
  logic         adv;
  logic [N-1:0] b_op;
  logic         c_first;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;
  assign b_op     = sub ? ~b : b;
  assign c_first  = sub | cin;

  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int LO = k * BLK;
    localparam int HI = N - LO - BLK;

    logic [N-LO-1:0]     a_in;
    logic [N-LO-1:0]     b_in;
    logic                c_in;
    logic                vld_in;
    logic [LO+BLK-1:0]   sum_new;
    logic [BLK:0]        s0;
    logic [BLK:0]        s1;
    logic [BLK:0]        sel;
    logic [LO+BLK-1:0]   sum_d;
    logic [LO+BLK-1:0]   sum_q;
    logic                c_d;
    logic                c_q;
    logic                vld_d;
    logic                vld_q;

    if (k == 0) begin : g_src
      assign a_in    = a;
      assign b_in    = b_op;
      assign c_in    = c_first;
      assign vld_in  = in_valid;
      assign sum_new = sel[BLK-1:0];
    end else begin : g_src
      assign a_in    = g_stage[k-1].g_ops.a_q;
      assign b_in    = g_stage[k-1].g_ops.b_q;
      assign c_in    = g_stage[k-1].c_q;
      assign vld_in  = g_stage[k-1].vld_q;
      assign sum_new = {sel[BLK-1:0], g_stage[k-1].sum_q};
    end

    // Local sum with carry-in 0 and its increment; the incoming carry picks one.
    always_comb begin
      s0  = {1'b0, a_in[BLK-1:0]} + {1'b0, b_in[BLK-1:0]};
      s1  = s0 + (BLK+1)'(1);
      sel = c_in ? s1 : s0;
    end

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      sum_d = sum_q;
      if (adv) begin
        vld_d = vld_in;
        if (vld_in) begin
          c_d   = sel[BLK];
          sum_d = sum_new;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    if (HI > 0) begin : g_ops
      logic [HI-1:0] a_d;
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_d;
      logic [HI-1:0] b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv && vld_in) begin
          a_d = a_in[N-LO-1:BLK];
          b_d = b_in[N-LO-1:BLK];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == NB - 1) begin : g_last
      logic c_msb;
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB recovered from the MSB sum bit and its operand bits.
      assign c_msb = sel[BLK-1] ^ a_in[BLK-1] ^ b_in[BLK-1];

      always_comb begin
        ovf_d = ovf_q;
        if (adv && vld_in) begin
          ovf_d = sel[BLK] ^ c_msb;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NB-1].vld_q;
  assign sum       = g_stage[NB-1].sum_q;
  assign cout      = g_stage[NB-1].c_q;
  assign ovf       = g_stage[NB-1].g_last.ovf_q;

endmodule

// File: tb/tb_cia_pipelined_adder.sv
// Bench for cia_pipelined_adder: spec vector table, latency/stall/reset sequences,
// then randomized traffic against a signed/unsigned arithmetic reference model.
module tb_cia_pipelined_adder;

  localparam int N   = 16;
  localparam int BLK = 4;
  localparam int NB  = N / BLK;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  vec_t           vecs [10];
  logic [N+1:0]   exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic           prev_hold = 1'b0;
  logic [N+1:0]   prev_out  = '0;
  logic           rnd_done;

  always #5 clk = ~clk;

  cia_pipelined_adder #(.N(N), .BLK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: unsigned carry/borrow and signed range check on plain integers.
  function automatic logic [N+1:0] model(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                         input logic fcin, input logic fsub);
    int ua, ub, sa, sb, ci, tot, st;
    logic c, o;
    logic [N-1:0] s;
    ua = int'(fa);
    ub = int'(fb);
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    ci = fcin ? 1 : 0;
    if (fsub) begin
      c   = (ua >= ub);
      tot = ua - ub;
      st  = sa - sb;
    end else begin
      tot = ua + ub + ci;
      c   = (tot >= (1 << N));
      st  = sa + sb + ci;
    end
    s = tot[N-1:0];
    o = (st > (1 << (N-1)) - 1) || (st < -(1 << (N-1)));
    return {o, c, s};
  endfunction

  function automatic vec_t mk(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                              input logic vs, input logic [N-1:0] vsum, input logic vco,
                              input logic vo);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.sum = vsum; v.cout = vco; v.ovf = vo;
    return v;
  endfunction

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return {1'b0, {(N-1){1'b1}}};
      default: return N'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expire(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Scoreboard: every output transfer must match the oldest expected result.
  always @(negedge clk) begin
    logic [N+1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", 32'({ovf, cout, sum}), 32'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected none at %0t", {ovf, cout, sum}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 32'({ovf, cout, sum}), 32'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {ovf, cout, sum};
    end
  end

  task automatic drive_one(input logic [N-1:0] da, input logic [N-1:0] db, input logic dc,
                           input logic ds, input logic [N+1:0] e);
    bit ok;
    ok = 1'b0;
    a = da; b = db; cin = dc; sub = ds;
    in_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) exp_q.push_back(e);
    else expire("drive_in_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_vec(input int i);
    drive_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
              {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
  endtask

  task automatic wait_out(input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) expire(nm);
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(16'hADC0, 16'hFE80, 1'b1, 1'b0, 16'hAC41, 1'b1, 1'b0);
    vecs[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[2] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vecs[3] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[4] = mk(16'h3A9A, 16'hE544, 1'b0, 1'b0, 16'h1FDE, 1'b1, 1'b0);
    vecs[5] = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    vecs[6] = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    vecs[7] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[8] = mk(16'h5555, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    vecs[9] = mk(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; rnd_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table vectors, back to back
    for (int i = 0; i < 10; i++) drive_vec(i);
    drain("table_drain");

    // Latency: accepted at edge t, visible after edge t+NB-1
    a = vecs[0].a; b = vecs[0].b; cin = vecs[0].cin; sub = vecs[0].sub;
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({vecs[0].ovf, vecs[0].cout, vecs[0].sum});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (NB - 1) begin
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    drain("lat_drain");

    // Back-to-back results on consecutive cycles
    drive_vec(1);
    drive_vec(2);
    wait_out("b2b_first");
    @(negedge clk);
    chk("b2b_consecutive", 32'(out_valid), 32'd1);
    drain("b2b_drain");

    // Stall for 3 cycles with the first result held; junk offered meanwhile
    drive_vec(4);
    drive_vec(6);
    drive_vec(5);
    out_ready = 1'b0;
    wait_out("stall_first");
    in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'h1FDE);
      chk("stall_cout", 32'(cout), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("stall_drain");
    repeat (NB + 1) begin
      @(negedge clk);
      chk("stall_no_extra", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset with two sets in flight
    drive_vec(0);
    drive_vec(7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Reset discarding a result held under stall
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive_vec(3);
    wait_out("heldrst_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("heldrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and idle cycles
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          logic [N-1:0] ra, rb;
          logic rc, rs;
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            a = N'($urandom); b = N'($urandom);
            @(posedge clk);
            #1;
          end else begin
            ra = pick_operand();
            rb = pick_operand();
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            drive_one(ra, rb, rc, rs, model(ra, rb, rc, rs));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
